// File: rtl/fft_peak_scheduler.sv
// fft_peak_scheduler: scans a range of FFT bins for the largest magnitude,
// hands that bin's index and phase to freq_estimator, and publishes the
// estimator result as a one-cycle-valid frequency word. One frame can be
// queued while busy. Defining FREQ_SCHED_TIMEOUT_EN adds an estimator
// watchdog; without it est_timeout is tied low.
module fft_peak_scheduler #(
    parameter int unsigned LO_BIN  = 1,
    parameter int unsigned HI_BIN  = 255,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid,
    input  logic [31:0] mag_thresh,
    output logic        bin_rd,
    output logic [8:0]  bin_addr,
    input  logic [31:0] bin_mag,
    input  logic [31:0] bin_phase,
    output logic        est_start,
    output logic [8:0]  est_max_index,
    output logic [31:0] est_max_phase,
    input  logic        est_done,
    input  logic [31:0] est_frequency,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        no_peak,
    output logic        frame_drop,
    output logic        est_timeout,
    output logic        busy
);
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] LO_ADDR = AW'(LO_BIN);
    localparam logic [AW-1:0] HI_ADDR = AW'(HI_BIN);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_START, S_ARM, S_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic          rd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] best_mag, best_phase;
    logic [AW-1:0] best_idx;
    logic          pending;
    logic          win_c, timeout_c;
    logic [DW-1:0] cand_mag_c, cand_phase_c;
    logic [AW-1:0] cand_idx_c;

    logic          bin_rd_d, est_start_d, freq_valid_d, no_peak_d;
    logic          frame_drop_d, est_timeout_d, busy_d;
    logic [AW-1:0] bin_addr_d, est_max_index_d;
    logic [DW-1:0] est_max_phase_d, freq_out_d;

    // Running peak including the sample returning this cycle (ties keep the lower bin)
    always_comb begin
        win_c        = rd_q && (bin_mag > best_mag);
        cand_mag_c   = win_c ? bin_mag   : best_mag;
        cand_phase_c = win_c ? bin_phase : best_phase;
        cand_idx_c   = win_c ? addr_q    : best_idx;
    end

`ifdef FREQ_SCHED_TIMEOUT_EN
    localparam logic [10:0] TO_LIM = 11'(TIMEOUT);
    logic [10:0] wd_cnt;

    // Watchdog: cleared on entry to START, counts every cycle in ARM and WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state_nxt == S_START) begin
            wd_cnt <= '0;
        end else if (state == S_ARM || state == S_WAIT) begin
            wd_cnt <= wd_cnt + 11'd1;
        end
    end

    assign timeout_c = (state == S_ARM || state == S_WAIT) && (wd_cnt == TO_LIM - 11'd1);
`else
    logic unused_timeout;
    assign unused_timeout = |11'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_valid || pending) state_nxt = S_SCAN;
            S_SCAN:  if (bin_addr == HI_ADDR) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = (cand_mag_c < mag_thresh) ? S_IDLE : S_START;
            S_START: state_nxt = S_ARM;
            S_ARM: begin
                if (!est_done)      state_nxt = S_WAIT;
                else if (timeout_c) state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (est_done)       state_nxt = S_IDLE;
                else if (timeout_c) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        bin_rd_d        = 1'b0;
        bin_addr_d      = bin_addr;
        est_start_d     = 1'b0;
        est_max_index_d = est_max_index;
        est_max_phase_d = est_max_phase;
        freq_out_d      = freq_out;
        freq_valid_d    = 1'b0;
        no_peak_d       = 1'b0;
        est_timeout_d   = 1'b0;
        frame_drop_d    = (state != S_IDLE) && frame_valid && pending;
        busy_d          = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: begin
                bin_addr_d = LO_ADDR;
                bin_rd_d   = (state_nxt == S_SCAN);
            end
            S_SCAN: begin
                if (bin_addr != HI_ADDR) begin
                    bin_rd_d   = 1'b1;
                    bin_addr_d = bin_addr + 9'd1;
                end
            end
            S_DRAIN: begin
                if (cand_mag_c < mag_thresh) begin
                    no_peak_d = 1'b1;
                end else begin
                    est_max_index_d = cand_idx_c;
                    est_max_phase_d = cand_phase_c;
                    est_start_d     = 1'b1;
                end
            end
            S_ARM: begin
                if (est_done && timeout_c) est_timeout_d = 1'b1;
            end
            S_WAIT: begin
                if (est_done) begin
                    freq_out_d   = est_frequency;
                    freq_valid_d = 1'b1;
                end else if (timeout_c) begin
                    est_timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_rd        <= 1'b0;
            bin_addr      <= LO_ADDR;
            est_start     <= 1'b0;
            est_max_index <= '0;
            est_max_phase <= '0;
            freq_out      <= '0;
            freq_valid    <= 1'b0;
            no_peak       <= 1'b0;
            frame_drop    <= 1'b0;
            est_timeout   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bin_rd        <= bin_rd_d;
            bin_addr      <= bin_addr_d;
            est_start     <= est_start_d;
            est_max_index <= est_max_index_d;
            est_max_phase <= est_max_phase_d;
            freq_out      <= freq_out_d;
            freq_valid    <= freq_valid_d;
            no_peak       <= no_peak_d;
            frame_drop    <= frame_drop_d;
            est_timeout   <= est_timeout_d;
            busy          <= busy_d;
        end
    end

    // Read pipeline tracking, best-peak register and one-deep frame queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= 1'b0;
            addr_q     <= LO_ADDR;
            best_mag   <= '0;
            best_idx   <= LO_ADDR;
            best_phase <= '0;
            pending    <= 1'b0;
        end else begin
            rd_q   <= bin_rd;
            addr_q <= bin_addr;
            if (state == S_IDLE) begin
                best_mag   <= '0;
                best_idx   <= LO_ADDR;
                best_phase <= '0;
            end else if (win_c) begin
                best_mag   <= bin_mag;
                best_idx   <= addr_q;
                best_phase <= bin_phase;
            end
            if (state == S_IDLE) begin
                // Consuming the queued frame; a frame arriving now re-queues it
                if (pending) pending <= frame_valid;
            end else if (frame_valid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_scheduler.sv
// Testbench for fft_peak_scheduler: table of scan scenarios plus directed
// sequences for queueing, async reset and (when enabled) the watchdog.
module tb_fft_peak_scheduler;
    localparam int unsigned LO = 1;
    localparam int unsigned HI = 255;
    localparam int unsigned N  = HI - LO + 1;
`ifdef FREQ_SCHED_TIMEOUT_EN
    localparam int unsigned TO = 20;
`else
    localparam int unsigned TO = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [31:0] mag_thresh = '0;
    logic        bin_rd;
    logic [8:0]  bin_addr;
    logic [31:0] bin_mag = '0;
    logic [31:0] bin_phase = '0;
    logic        est_start;
    logic [8:0]  est_max_index;
    logic [31:0] est_max_phase;
    logic        est_done = 1'b1;
    logic [31:0] est_frequency = '0;
    logic [31:0] freq_out;
    logic        freq_valid, no_peak, frame_drop, est_timeout, busy;

    always #5 clk = ~clk;

    fft_peak_scheduler #(.LO_BIN(LO), .HI_BIN(HI), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .mag_thresh(mag_thresh),
        .bin_rd(bin_rd), .bin_addr(bin_addr), .bin_mag(bin_mag), .bin_phase(bin_phase),
        .est_start(est_start), .est_max_index(est_max_index), .est_max_phase(est_max_phase),
        .est_done(est_done), .est_frequency(est_frequency), .freq_out(freq_out),
        .freq_valid(freq_valid), .no_peak(no_peak), .frame_drop(frame_drop),
        .est_timeout(est_timeout), .busy(busy)
    );

    // Bin buffer: one-cycle read latency
    logic [31:0] mag_mem   [512];
    logic [31:0] phase_mem [512];
    always @(posedge clk) begin
        if (bin_rd) begin
            bin_mag   <= mag_mem[bin_addr];
            bin_phase <= phase_mem[bin_addr];
        end
    end

    // Estimator: drops done on start, raises it with the result 12 cycles later
    logic        est_hang = 1'b0;
    logic [31:0] est_result = '0;
    int          ecnt = 0;
    always @(posedge clk) begin
        if (est_start) begin
            est_done <= 1'b0;
            ecnt     <= 12;
        end else if (!est_done && !est_hang) begin
            if (ecnt == 1) begin
                est_done      <= 1'b1;
                est_frequency <= est_result;
            end
            ecnt <= ecnt - 1;
        end
    end

    // Event counters and operand-stability monitor
    int          n_start = 0, n_fv = 0, n_np = 0, n_drop = 0, n_to = 0;
    int          n_scan = 0, n_bad_addr = 0, n_unstable = 0;
    logic        rd_prev = 1'b0, trk = 1'b0;
    logic [8:0]  cap_idx = '0;
    logic [31:0] cap_ph = '0;
    always @(negedge clk) begin
        if (est_start)   n_start++;
        if (freq_valid)  n_fv++;
        if (no_peak)     n_np++;
        if (frame_drop)  n_drop++;
        if (est_timeout) n_to++;
        if (bin_rd && !rd_prev) n_scan++;
        rd_prev = bin_rd;
        if (bin_rd && (bin_addr < 9'(LO) || bin_addr > 9'(HI))) n_bad_addr++;
        if (est_start) begin
            trk     = 1'b1;
            cap_idx = est_max_index;
            cap_ph  = est_max_phase;
        end else if (trk && (est_max_index != cap_idx || est_max_phase != cap_ph)) begin
            n_unstable++;
        end
        if (freq_valid || est_timeout || !rst_n) trk = 1'b0;
    end

    typedef struct {
        int unsigned b1;  logic [31:0] m1; logic [31:0] p1;
        int unsigned b2;  logic [31:0] m2;
        logic [31:0] base; logic [31:0] thresh; logic [31:0] freq;
        bit exp_np; int unsigned exp_idx; logic [31:0] exp_ph;
    } vec_t;

    int          n_chk = 0, n_err = 0;
    logic [31:0] last_freq = '0;
    vec_t        vecs [6];

    function automatic logic [31:0] phase_of(input int i);
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 512; i++) begin
            mag_mem[i]   = v.base;
            phase_mem[i] = phase_of(i);
        end
        // Out-of-range bins would win any scan that wrongly reads them
        mag_mem[0]   = 32'hFFFF_FFFF;
        mag_mem[256] = 32'hFFFF_FFFF;
        mag_mem[v.b2] = v.m2;
        mag_mem[v.b1] = v.m1;
        phase_mem[v.b1] = v.p1;
        mag_thresh = v.thresh;
        est_result = v.freq;
    endtask

    task automatic pulse_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int start_c, end_c, cyc, s_start, s_unst, s_bad, s_scan;
        bit np_seen;
        load(v);
        s_start = n_start; s_unst = n_unstable; s_bad = n_bad_addr; s_scan = n_scan;
        start_c = -1; end_c = -1; np_seen = 0;
        pulse_frame();
        cyc = 1;
        while (cyc < 1000 && end_c < 0) begin
            if (est_start && start_c < 0) start_c = cyc;
            if (freq_valid || no_peak) begin
                end_c   = cyc;
                np_seen = no_peak;
            end
            if (end_c < 0) begin
                step();
                cyc++;
            end
        end
        chk($sformatf("v%0d_finished", id), 32'(end_c >= 0), 32'd1);
        chk($sformatf("v%0d_no_peak", id), 32'(np_seen), 32'(v.exp_np));
        if (v.exp_np) begin
            chk($sformatf("v%0d_no_peak_time", id), 32'(end_c), 32'(N + 2));
            chk($sformatf("v%0d_no_start", id), 32'(n_start - s_start), 32'd0);
            chk($sformatf("v%0d_freq_kept", id), freq_out, last_freq);
        end else begin
            chk($sformatf("v%0d_start_lat", id), 32'(start_c), 32'(N + 2));
            chk($sformatf("v%0d_fv_time", id), 32'(end_c), 32'(N + 2 + 14));
            chk($sformatf("v%0d_idx", id), 32'(est_max_index), 32'(v.exp_idx));
            chk($sformatf("v%0d_phase", id), est_max_phase, v.exp_ph);
            chk($sformatf("v%0d_freq", id), freq_out, v.freq);
            chk($sformatf("v%0d_stable", id), 32'(n_unstable - s_unst), 32'd0);
            last_freq = v.freq;
        end
        step();
        chk($sformatf("v%0d_pulse_width", id), 32'({freq_valid, no_peak}), 32'd0);
        chk($sformatf("v%0d_idle", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d_addr_range", id), 32'(n_bad_addr - s_bad), 32'd0);
        chk($sformatf("v%0d_one_scan", id), 32'(n_scan - s_scan), 32'd1);
    endtask

    initial begin
        int cyc, s0, t0, s_drop, s_scan, s_fv, s_start, s_np;

        //         b1   m1    p1                b2   m2   base thresh freq          np idx ph
        vecs[0] = '{40,  900,  32'h0010_0000,   40,  900, 5,   0,     32'h1B80_0000, 0, 40,  32'h0010_0000};
        vecs[1] = '{1,   700,  32'h5A5A_0001,   255, 700, 0,   0,     32'h0ABC_0000, 0, 1,   32'h5A5A_0001};
        vecs[2] = '{100, 999,  32'h5A5A_0064,   100, 999, 0,   1000,  32'h0000_0000, 1, 0,   32'h0};
        vecs[3] = '{255, 1000, 32'hDEAD_BEEF,   255, 1000,0,   1000,  32'h1234_5678, 0, 255, 32'hDEAD_BEEF};
        vecs[4] = '{50,  0,    32'h1111_1111,   50,  0,   0,   0,     32'h7FFF_0000, 0, 1,   32'h0};
        vecs[5] = '{200, 61,   32'hCAFE_0000,   100, 60,  3,   61,    32'h0040_0000, 0, 200, 32'hCAFE_0000};

        // Reset state
        step(); step();
        chk("rst_bin_rd", 32'(bin_rd), 32'd0);
        chk("rst_bin_addr", 32'(bin_addr), 32'(LO));
        chk("rst_outputs", 32'({est_start, freq_valid, no_peak, frame_drop, est_timeout, busy}), 32'd0);
        chk("rst_est_idx", 32'(est_max_index), 32'd0);
        chk("rst_freq_out", freq_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Queueing: two frames during WAIT -> one queued, one dropped
        load(vecs[0]);
        s_drop = n_drop; s_scan = n_scan; s_fv = n_fv;
        pulse_frame();
        cyc = 0;
        while (!est_start && cyc < 1000) begin step(); cyc++; end
        chk("q_started", 32'(est_start), 32'd1);
        repeat (4) step();
        pulse_frame();
        step();
        pulse_frame();
        cyc = 0;
        while (!freq_valid && cyc < 100) begin step(); cyc++; end
        chk("q_first_done", 32'(freq_valid), 32'd1);
        chk("q_idle_gap", 32'({bin_rd, busy}), 32'd0);
        step();
        chk("q_rescan_rd", 32'(bin_rd), 32'd1);
        chk("q_rescan_addr", 32'(bin_addr), 32'(LO));
        cyc = 0;
        while (!freq_valid && cyc < 1000) begin step(); cyc++; end
        chk("q_second_done", 32'(freq_valid), 32'd1);
        repeat (600) step();
        chk("q_drops", 32'(n_drop - s_drop), 32'd1);
        chk("q_scans", 32'(n_scan - s_scan), 32'd2);
        chk("q_results", 32'(n_fv - s_fv), 32'd2);

        // Async reset in the middle of a scan
        load(vecs[1]);
        pulse_frame();
        cyc = 0;
        while (!(bin_rd && bin_addr == 9'd100) && cyc < 400) begin step(); cyc++; end
        chk("r_reached_100", 32'(bin_addr), 32'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("r_bin_rd", 32'(bin_rd), 32'd0);
        chk("r_bin_addr", 32'(bin_addr), 32'(LO));
        chk("r_pulses_busy", 32'({est_start, freq_valid, no_peak, frame_drop, est_timeout, busy}), 32'd0);
        chk("r_est_operands", 32'(est_max_index) | est_max_phase, 32'd0);
        chk("r_freq_out", freq_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_freq = '0;
        s_start = n_start; s_fv = n_fv; s_np = n_np; s_scan = n_scan;
        repeat (400) step();
        chk("r_quiet", 32'((n_start - s_start) + (n_fv - s_fv) + (n_np - s_np) + (n_scan - s_scan)), 32'd0);
        chk("r_idle", 32'(busy), 32'd0);
        run_vec(6, vecs[0]);

`ifdef FREQ_SCHED_TIMEOUT_EN
        // Watchdog: estimator accepts the start but never finishes
        load(vecs[3]);
        est_hang = 1'b1;
        s_fv = n_fv;
        pulse_frame();
        cyc = 1; s0 = -1; t0 = -1;
        while (t0 < 0 && cyc < 1000) begin
            if (est_start && s0 < 0) s0 = cyc;
            if (est_timeout) t0 = cyc;
            if (t0 < 0) begin step(); cyc++; end
        end
        chk("wd_fired_at", 32'(t0 - s0), 32'd21);
        chk("wd_no_result", 32'(n_fv - s_fv), 32'd0);
        chk("wd_freq_kept", freq_out, last_freq);
        step();
        chk("wd_idle", 32'({busy, est_timeout}), 32'd0);
`else
        s0 = 0; t0 = 0;
        chk("no_watchdog_pulses", 32'(n_to), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
